pattern_1100_gen: RTL and testbench
===================================

# pattern_1100_gen

Serial stimulus transmitter for the 1100 sequence detectors: emits a bitstream of `count` inserted "1100" patterns, each preceded by `gap` filler bits. The gap filler comes from an internal 16-bit Galois LFSR. A registered `mark` flags every cycle in which an emitted bit completes a 1100 occurrence, giving benches a golden expectation for any detector (Moore or Mealy) driven from `x`. The block sits on the stimulus side of detector testbenches and replaces the bare LFSR feed.

## Interface
Parameters:
- GAP_W, 8, width of the gap-length input
- CNT_W, 8, width of the pattern-count input and of the `sent` counter
- SEED, 16'hACE1, LFSR reset value; a SEED of 0 is replaced by 16'h0001

Ports:
- Clock  in  1  single clock; all logic is on its rising edge
- Reset  in  1  synchronous, active-high reset
- start  in  1  request to begin a burst; sampled only in IDLE
- gap  in  GAP_W  filler bits before each pattern; latched at start acceptance
- count  in  CNT_W  number of patterns in the burst; latched at start acceptance
- x  out  1  serial data bit
- valid  out  1  `x` is part of the burst in this cycle
- mark  out  1  `x` completes a "1100" sequence within the current burst
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after the final burst bit
- sent  out  CNT_W  inserted patterns completed in the current or last burst

## Operation
- Reset values: x=0, valid=0, mark=0, busy=0, done=0, sent=0, LFSR=SEED, history=0, state IDLE.
- FSM states: IDLE, GAP, PAT, FIN.
- IDLE with start=1:
  - latch gap and count, clear `sent` and the 4-bit history, set busy.
  - count=0 → FIN.
  - gap=0 → PAT.
  - otherwise → GAP.
- IDLE with start=0: hold all outputs (`sent` keeps its last value) and keep valid=0.
- GAP: emit one filler bit per cycle with valid=1, for exactly `gap` cycles, then → PAT.
- PAT: emit 1,1,0,0 over 4 cycles with valid=1. On the fourth bit `sent` increments.
  - If sent+1 == count → FIN.
  - Otherwise → GAP, or → PAT again if gap=0.
- FIN: one cycle with done=1, busy=0, valid=0, then → IDLE.
- start is ignored while busy=1 or in FIN.
- Filler bit = LFSR[0]. The LFSR advances only in cycles that emit a filler bit. Update rule: lfsr ← (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
- mark:
  - history is a shift register of the last 3 valid bits.
  - mark=1 when {history, x} == 4'b1100 for the bit being emitted.
  - Filler-created occurrences are flagged as well as inserted ones.
  - 1100 is non-self-overlapping, so no double counting occurs.
- `sent` counts inserted patterns only. Wraps never occur because count ≤ 2^CNT_W−1.
- x=0 whenever valid=0.

## Timing
- All outputs are registered.
- Start accepted at edge N → busy=1 and the first valid bit after edge N+1.
- Burst length is count×(gap+4) valid cycles. done is asserted one cycle after the last valid bit.
- With count=0: busy=1 for one cycle, then done=1 in the following cycle.
- mark is coincident with its completing `x`:
  - a Moore detector's y is expected one cycle after mark;
  - a Mealy detector's y is expected in the same cycle as mark.
- Reset asserted mid-burst: next cycle all outputs are at reset values, LFSR is reseeded, and the partial pattern is discarded.

## Configuration
- LFSR_FILL_EN defined: gap filler comes from the LFSR as above.
- LFSR_FILL_EN undefined:
  - gap filler is constant 0 and the LFSR is not instantiated;
  - mark then fires only on inserted patterns, so mark count equals `sent` at done.

## Structure
- Package `gen1100_pkg`:
  - state enum {IDLE, GAP, PAT, FIN};
  - constant PATTERN = 4'b1100;
  - constant LFSR_TAPS = 16'hB400.
- Sub-module `galois_lfsr16`, with ports Clock, Reset, en, q[15:0] and the SEED parameter. It is instantiated only under LFSR_FILL_EN.

## Test plan
- Reset then idle 10 cycles: valid=0, x=0, busy=0, sent=0 throughout.
- Build without LFSR_FILL_EN, gap=2, count=3:
  - x stream is 00 1100 00 1100 00 1100, valid for 18 cycles;
  - mark on cycles 6, 12, 18;
  - done one cycle later, sent=3.
- gap=0, count=2: x = 11001100 with no idle bit between patterns; mark on cycles 4 and 8; sent=2.
- count=0: busy pulse, then done pulse, with no valid cycle; sent=0.
- Build with LFSR_FILL_EN, SEED=16'hACE1, gap=20, count=5:
  - filler bits match a software model of the Galois LFSR;
  - mark count equals the scoreboard count of 1100 occurrences, which is ≥ 5;
  - start pulses during busy are ignored.
- Reset asserted during the second pattern of a count=4 burst: next cycle busy=0 and sent=0. A fresh start reproduces the first burst's stream bit-for-bit.

Source files
------------

// File: rtl/gen1100_pkg.sv
// rtl/gen1100_pkg.sv - shared types and constants for the 1100 stimulus generator
//
// Purpose : FSM state encoding, the inserted pattern and the Galois LFSR taps.
// Ports   : none (package).
package gen1100_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    PAT  = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Pattern bits are emitted MSB first: 1, 1, 0, 0.
  localparam logic [3:0]  PATTERN   = 4'b1100;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/galois_lfsr16.sv
// rtl/galois_lfsr16.sv - 16-bit Galois LFSR used as the gap filler source
//
// Purpose : right-shifting Galois LFSR; advances only when en=1.
// Ports   : Clock  - rising-edge clock
//           Reset  - synchronous active-high reset, loads SEED (0 maps to 1)
//           en     - advance one step this cycle
//           q      - current LFSR state; q[0] is the next filler bit
module galois_lfsr16
  import gen1100_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        en,
  output logic [15:0] q
);

  // An all-zero state would lock the LFSR, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      q <= SEED_EFF;
    end else if (en) begin
      q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/pattern_1100_gen.sv
// rtl/pattern_1100_gen.sv - serial 1100 pattern stimulus transmitter
//
// Purpose : emits `count` inserted 1100 patterns, each preceded by `gap`
//           filler bits, and flags every emitted bit that completes a 1100.
// Macro   : LFSR_FILL_EN - filler bits come from galois_lfsr16; when
//           undefined the filler is constant 0 and no LFSR is built.
// Ports   : Clock, Reset - rising-edge clock, synchronous active-high reset
//           start        - begin a burst (sampled only in IDLE)
//           gap, count   - filler length / pattern count, latched at start
//           x, valid     - serial bit and its qualifier
//           mark         - x completes a 1100 within the current burst
//           busy, done   - burst in progress / one-cycle end pulse
//           sent         - inserted patterns completed in this/last burst
module pattern_1100_gen
  import gen1100_pkg::*;
#(
  parameter int          GAP_W = 8,
  parameter int          CNT_W = 8,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [GAP_W-1:0] gap,
  input  logic [CNT_W-1:0] count,
  output logic             x,
  output logic             valid,
  output logic             mark,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent
);

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_lat;
  logic [CNT_W-1:0] cnt_lat;
  logic [GAP_W-1:0] gap_cnt;   // filler bits still to emit in this gap
  logic [1:0]       pat_idx;   // position inside the inserted pattern
  logic [2:0]       hist;      // last three valid bits of the burst

  logic fill_bit;
  logic emit_valid, emit_bit, emit_mark;
  logic accept, pat_last, burst_last;

  assign accept     = (state_q == IDLE) && start;
  assign pat_last   = (state_q == PAT) && (pat_idx == 2'd3);
  assign burst_last = pat_last && ((sent + CNT_W'(1)) == cnt_lat);

`ifdef LFSR_FILL_EN
  logic [15:0] lfsr_q;
  logic        lfsr_en;

  // Advance only on cycles that actually consume a filler bit.
  assign lfsr_en = (state_q == GAP);

  galois_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .Clock (Clock),
    .Reset (Reset),
    .en    (lfsr_en),
    .q     (lfsr_q)
  );

  assign fill_bit = lfsr_q[0];
`else
  assign fill_bit = 1'b0;
`endif

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            state_d = FIN;
          end else if (gap == '0) begin
            state_d = PAT;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          state_d = PAT;
        end
      end
      PAT: begin
        if (burst_last) begin
          state_d = FIN;
        end else if (pat_last) begin
          state_d = (gap_lat == '0) ? PAT : GAP;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the bit this state emits; registered below so that all
  // outputs appear one cycle after the state that produced them.
  always_comb begin
    emit_valid = 1'b0;
    emit_bit   = 1'b0;
    case (state_q)
      GAP: begin
        emit_valid = 1'b1;
        emit_bit   = fill_bit;
      end
      PAT: begin
        emit_valid = 1'b1;
        // ~pat_idx walks the pattern MSB first (3,2,1,0).
        emit_bit   = PATTERN[~pat_idx];
      end
      default: begin
        emit_valid = 1'b0;
        emit_bit   = 1'b0;
      end
    endcase
    emit_mark = emit_valid && ({hist, emit_bit} == PATTERN);
  end

  // Datapath and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      x       <= 1'b0;
      valid   <= 1'b0;
      mark    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sent    <= '0;
      gap_lat <= '0;
      cnt_lat <= '0;
      gap_cnt <= '0;
      pat_idx <= 2'd0;
      hist    <= 3'd0;
    end else begin
      x     <= emit_bit;
      valid <= emit_valid;
      mark  <= emit_mark;
      done  <= (state_q == FIN);

      if (accept) begin
        gap_lat <= gap;
        cnt_lat <= count;
        gap_cnt <= gap;
        pat_idx <= 2'd0;
        sent    <= '0;
        hist    <= 3'd0;
        busy    <= 1'b1;
      end

      if (emit_valid) begin
        hist <= {hist[1:0], emit_bit};
      end

      case (state_q)
        GAP: gap_cnt <= gap_cnt - GAP_W'(1);
        PAT: begin
          pat_idx <= pat_idx + 2'd1;
          if (pat_last) begin
            sent    <= sent + CNT_W'(1);
            gap_cnt <= gap_lat;
          end
        end
        FIN: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_1100_gen.sv
// tb/tb_pattern_1100_gen.sv - self-checking bench for pattern_1100_gen
module tb_pattern_1100_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] gap = 8'd0;
  logic [7:0] count = 8'd0;
  logic       x, valid, mark, busy, done;
  logic [7:0] sent;

  int checks = 0;
  int failures = 0;

  bit cap_bits[$];
  bit cap_marks[$];
  bit exp_bits[$];
  bit exp_marks[$];
  bit ref_bits[$];

  int         done_cyc, last_valid_cyc, stray;
  logic       busy_acc, valid_acc, busy_done;
  logic [7:0] sent_done;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  pattern_1100_gen #(
    .GAP_W (8),
    .CNT_W (8),
    .SEED  (16'hACE1)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .start (start),
    .gap   (gap),
    .count (count),
    .x     (x),
    .valid (valid),
    .mark  (mark),
    .busy  (busy),
    .done  (done),
    .sent  (sent)
  );

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    m_lfsr = 16'hACE1;
  endtask

  // Reference model of one burst: filler from a software LFSR (or 0), then 1100.
  task automatic model_burst(input int g, input int c);
    logic [3:0] h;
    bit         b;
    exp_bits.delete();
    exp_marks.delete();
    h = 4'd0;
    for (int p = 0; p < c; p++) begin
      for (int i = 0; i < g + 4; i++) begin
        if (i < g) begin
`ifdef LFSR_FILL_EN
          b      = m_lfsr[0];
          m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
`else
          b = 1'b0;
`endif
        end else begin
          b = (i - g) < 2;
        end
        h = {h[2:0], b};
        exp_bits.push_back(b);
        exp_marks.push_back(h == 4'b1100);
      end
    end
  endtask

  task automatic run_burst(input int g, input int c, input bit poke);
    int limit;
    limit = c * (g + 4) + 10;
    cap_bits.delete();
    cap_marks.delete();
    done_cyc       = -1;
    last_valid_cyc = -1;
    stray          = 0;
    sent_done      = 8'hxx;
    busy_done      = 1'bx;
    model_burst(g, c);
    @(negedge clk);
    gap   = g[7:0];
    count = c[7:0];
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    busy_acc  = busy;
    valid_acc = valid;
    for (int cyc = 1; cyc <= limit && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        cap_bits.push_back(x);
        cap_marks.push_back(mark);
        last_valid_cyc = cyc;
      end else if (x !== 1'b0 || mark !== 1'b0) begin
        stray++;
      end
      if (done === 1'b1) begin
        done_cyc  = cyc;
        sent_done = sent;
        busy_done = busy;
      end
      start = poke && (done !== 1'b1) && cyc[0];
    end
    start = 1'b0;
  endtask

  function automatic int stream_diff();
    int d;
    d = (cap_bits.size() > exp_bits.size()) ? cap_bits.size() - exp_bits.size()
                                            : exp_bits.size() - cap_bits.size();
    for (int i = 0; i < cap_bits.size() && i < exp_bits.size(); i++) begin
      if (cap_bits[i] != exp_bits[i] || cap_marks[i] != exp_marks[i]) d++;
    end
    return d;
  endfunction

  function automatic int count_marks(input bit q[$]);
    int n;
    n = 0;
    foreach (q[i]) n += q[i];
    return n;
  endfunction

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({valid, x, busy, done, mark} !== 5'b0 || sent !== 8'd0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got v=%b x=%b busy=%b done=%b mark=%b sent=%0d expected all 0",
                 i, valid, x, busy, done, mark, sent);
      end
    end
  endtask

  task automatic test_gap2_count3();
    logic [17:0] pb, pm;
    run_burst(2, 3, 1'b0);
    checks++;
    if (busy_acc !== 1'b1 || valid_acc !== 1'b0) begin
      failures++;
      $display("FAIL g2c3_accept got busy=%b valid=%b expected busy=1 valid=0", busy_acc, valid_acc);
    end
    checks++;
    if (cap_bits.size() != 18) begin
      failures++;
      $display("FAIL g2c3_len got %0d expected 18", cap_bits.size());
    end
    checks++;
    if (stream_diff() != 0) begin
      failures++;
      $display("FAIL g2c3_model got %0d differences expected 0", stream_diff());
    end
`ifndef LFSR_FILL_EN
    pb = '0;
    pm = '0;
    for (int i = 0; i < cap_bits.size() && i < 18; i++) begin
      pb = {pb[16:0], cap_bits[i]};
      pm = {pm[16:0], cap_marks[i]};
    end
    checks++;
    if (pb !== 18'b00_1100_00_1100_00_1100) begin
      failures++;
      $display("FAIL g2c3_bits got %b expected 001100001100001100", pb);
    end
    checks++;
    if (pm !== 18'b00_0001_00_0001_00_0001) begin
      failures++;
      $display("FAIL g2c3_marks got %b expected 000001000001000001", pm);
    end
`endif
    checks++;
    if (done_cyc < 0 || done_cyc - last_valid_cyc != 1 || busy_done !== 1'b0) begin
      failures++;
      $display("FAIL g2c3_done got done_cyc=%0d last_valid=%0d busy=%b expected done one cycle after, busy=0",
               done_cyc, last_valid_cyc, busy_done);
    end
    checks++;
    if (sent_done !== 8'd3 || stray != 0) begin
      failures++;
      $display("FAIL g2c3_sent got sent=%0d stray=%0d expected sent=3 stray=0", sent_done, stray);
    end
  endtask

  task automatic test_gap0();
    logic [7:0] pb, pm;
    run_burst(0, 2, 1'b0);
    pb = '0;
    pm = '0;
    for (int i = 0; i < cap_bits.size() && i < 8; i++) begin
      pb = {pb[6:0], cap_bits[i]};
      pm = {pm[6:0], cap_marks[i]};
    end
    checks++;
    if (cap_bits.size() != 8 || pb !== 8'b11001100) begin
      failures++;
      $display("FAIL gap0_bits got len=%0d bits=%b expected len=8 bits=11001100", cap_bits.size(), pb);
    end
    checks++;
    if (pm !== 8'b00010001) begin
      failures++;
      $display("FAIL gap0_marks got %b expected 00010001", pm);
    end
    checks++;
    if (sent_done !== 8'd2 || done_cyc != 9) begin
      failures++;
      $display("FAIL gap0_done got sent=%0d done_cyc=%0d expected sent=2 done_cyc=9", sent_done, done_cyc);
    end
  endtask

  task automatic test_count0();
    run_burst(5, 0, 1'b0);
    checks++;
    if (busy_acc !== 1'b1 || valid_acc !== 1'b0) begin
      failures++;
      $display("FAIL count0_busy got busy=%b valid=%b expected busy=1 valid=0", busy_acc, valid_acc);
    end
    checks++;
    if (done_cyc != 1 || cap_bits.size() != 0 || busy_done !== 1'b0) begin
      failures++;
      $display("FAIL count0_done got done_cyc=%0d valid_bits=%0d busy=%b expected 1, 0, 0",
               done_cyc, cap_bits.size(), busy_done);
    end
    checks++;
    if (sent_done !== 8'd0) begin
      failures++;
      $display("FAIL count0_sent got %0d expected 0", sent_done);
    end
  endtask

  task automatic test_long_burst();
    int nm;
    run_burst(20, 5, 1'b1);
    nm = count_marks(cap_marks);
    checks++;
    if (cap_bits.size() != 120) begin
      failures++;
      $display("FAIL long_len got %0d expected 120", cap_bits.size());
    end
    checks++;
    if (stream_diff() != 0) begin
      failures++;
      $display("FAIL long_model got %0d differences expected 0", stream_diff());
    end
    checks++;
    if (nm != count_marks(exp_marks) || nm < 5) begin
      failures++;
      $display("FAIL long_marks got %0d expected %0d (at least 5)", nm, count_marks(exp_marks));
    end
`ifndef LFSR_FILL_EN
    checks++;
    if (nm != 5) begin
      failures++;
      $display("FAIL long_marks_eq_sent got %0d expected 5", nm);
    end
`endif
    checks++;
    if (sent_done !== 8'd5) begin
      failures++;
      $display("FAIL long_sent got %0d expected 5", sent_done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL long_start_ignored got busy=%b valid=%b expected 0 0", busy, valid);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    do_reset();
    run_burst(3, 4, 1'b0);
    ref_bits = cap_bits;
    do_reset();
    @(negedge clk);
    gap   = 8'd3;
    count = 8'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 12; cyc++) begin
      @(negedge clk);
      if (valid === 1'b1) n++;
    end
    checks++;
    if (n != 12) begin
      failures++;
      $display("FAIL midrst_reach got %0d valid bits expected 12", n);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sent !== 8'd0 || {valid, x, mark, done} !== 4'b0) begin
      failures++;
      $display("FAIL midrst_state got busy=%b sent=%0d v=%b x=%b mark=%b done=%b expected all 0",
               busy, sent, valid, x, mark, done);
    end
    rst    = 1'b0;
    m_lfsr = 16'hACE1;
    run_burst(3, 4, 1'b0);
    checks++;
    if (cap_bits != ref_bits || cap_bits.size() != 28) begin
      failures++;
      $display("FAIL midrst_replay got len=%0d expected len=28 identical to first burst", cap_bits.size());
    end
    checks++;
    if (stream_diff() != 0 || sent_done !== 8'd4) begin
      failures++;
      $display("FAIL midrst_model got diff=%0d sent=%0d expected 0 and 4", stream_diff(), sent_done);
    end
  endtask

  initial begin
    m_lfsr = 16'hACE1;
    test_reset();
    test_gap2_count3();
    test_gap0();
    test_count0();
    test_long_burst();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
